sdram_page_reader: RTL and testbench



---
 rtl/sdram_page_reader_pkg.sv | 18 +
 rtl/sdram_page_reader_if.sv | 34 +++
 rtl/sync_fwft_fifo.sv | 68 ++++++
 rtl/sdram_page_reader.sv | 131 +++++++++++++
 tb/tb_sdram_page_reader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_page_reader_pkg.sv
// Shared definitions for the SDRAM page reader and the SDRAM responder it drives.
// Command encodings, burst geometry and the reader state type.
package sdram_page_reader_pkg;

   localparam logic [2:0] CMD_IDLE  = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;
   localparam logic [2:0] CMD_WRITE = 3'b010;

   localparam int unsigned BURST_LEN = 512;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StBurst,
      StWaitIdle
   } rd_state_e;

endpackage

// File: rtl/sdram_page_reader_if.sv
// Bundle between the page reader, the SDRAM responder read path and the pixel consumer.
// master = page reader side, slave = responder/consumer side.
interface sdram_page_reader_if #(
   parameter int unsigned FIFO_DEPTH = 1024
);
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic          enable;
   logic          frame_start;
   logic [2:0]    user_interface_command;
   logic [14:0]   f_addr;
   logic          in_idle;
   logic          w_fifo;
   logic [15:0]   s2f_data;
   logic [15:0]   pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic [LW-1:0] fifo_level;
   logic          underflow;
   logic          frame_done;

   modport master (
      input  enable, frame_start, in_idle, w_fifo, s2f_data, pix_ready,
      output user_interface_command, f_addr, pix_data, pix_valid, fifo_level, underflow,
             frame_done
   );

   modport slave (
      output enable, frame_start, in_idle, w_fifo, s2f_data, pix_ready,
      input  user_interface_command, f_addr, pix_data, pix_valid, fifo_level, underflow,
             frame_done
   );

endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with word-count output and synchronous flush.
// Head word is read straight from the register array, so it is valid alongside valid_o.
module sync_fwft_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             valid_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full, do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign valid_o = (level_q != '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   // A push into a full FIFO is dropped; flush wins over both push and pop.
   assign do_push = push_i & ~full & ~flush_i;
   assign do_pop  = pop_i & valid_o & ~flush_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop)  rptr_d = rptr_q + AW'(1);
         level_d = level_q + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && full && !flush_i));

endmodule

// File: rtl/sdram_page_reader.sv
// Issues full-page SDRAM reads over a linear frame of pages and streams the returned
// bursts to the scanout logic through an on-chip FWFT FIFO.
module sdram_page_reader
   import sdram_page_reader_pkg::*;
#(
   parameter logic [14:0] BASE_PAGE   = 15'd0,
   parameter logic [15:0] FRAME_PAGES = 16'd600,
   parameter int unsigned FIFO_DEPTH  = 1024
) (
   input logic                 sram_clk,
   input logic                 rst_n,
   sdram_page_reader_if.master bus_if
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] ROOM_MAX = LW'(FIFO_DEPTH - BURST_LEN);

   rd_state_e   state_q, state_d;
   logic [15:0] page_q, page_d;
   logic [9:0]  beat_q, beat_d;
   logic        restart_q, restart_d;
   logic        underflow_q, underflow_d;
   logic        frame_done_q, frame_done_d;
   logic        restart_pend, push, flush;
   logic [LW-1:0] level;
   logic        pix_valid;

   assign restart_pend = restart_q | bus_if.frame_start;

   always_comb begin
      state_d      = state_q;
      page_d       = page_q;
      beat_d       = beat_q;
      restart_d    = restart_q;
      frame_done_d = 1'b0;
      push         = 1'b0;
      flush        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_if.frame_start) begin
               flush  = 1'b1;
               page_d = '0;
            end else if (bus_if.enable && (level <= ROOM_MAX) && bus_if.in_idle &&
                         (page_q < FRAME_PAGES) && !restart_q) begin
               state_d = StReq;
            end
         end
         StReq: begin
            restart_d = restart_pend;
            if (!bus_if.in_idle) state_d = StBurst;
         end
         StBurst: begin
            restart_d = restart_pend;
            if (bus_if.w_fifo) begin
               // Words of a burst interrupted by a restart are drained but not kept.
               push   = ~restart_pend;
               beat_d = beat_q + 10'd1;
               if (beat_q == 10'(BURST_LEN - 1)) begin
                  beat_d  = '0;
                  state_d = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            restart_d = restart_pend;
            if (bus_if.in_idle) begin
               state_d   = StIdle;
               restart_d = 1'b0;
               if (restart_pend) begin
                  flush  = 1'b1;
                  page_d = '0;
               end else begin
                  page_d       = page_q + 16'd1;
                  frame_done_d = ((page_q + 16'd1) == FRAME_PAGES);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      underflow_d = underflow_q | (bus_if.pix_ready & ~pix_valid & bus_if.enable);
      if (bus_if.frame_start) underflow_d = 1'b0;
   end

   always_ff @(posedge sram_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         page_q       <= '0;
         beat_q       <= '0;
         restart_q    <= 1'b0;
         underflow_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         page_q       <= page_d;
         beat_q       <= beat_d;
         restart_q    <= restart_d;
         underflow_q  <= underflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   sync_fwft_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (sram_clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (bus_if.s2f_data),
      .pop_i   (bus_if.pix_ready),
      .rdata_o (bus_if.pix_data),
      .valid_o (pix_valid),
      .level_o (level)
   );

   // Command is high only while waiting for the responder to leave idle.
   assign bus_if.user_interface_command = (state_q == StReq) ? CMD_READ : CMD_IDLE;
   assign bus_if.f_addr     = BASE_PAGE + page_q[14:0];
   assign bus_if.pix_valid  = pix_valid;
   assign bus_if.fifo_level = level;
   assign bus_if.underflow  = underflow_q;
   assign bus_if.frame_done = frame_done_q;

   never_write: assert property (@(posedge sram_clk) disable iff (!rst_n)
      bus_if.user_interface_command != CMD_WRITE);

endmodule

// File: tb/tb_sdram_page_reader.sv
// Directed-plus-random bench: a randomised SDRAM responder, a queue model of the expected
// pixel stream and a per-cycle monitor of the consumer-side outputs.
module tb_sdram_page_reader;
   import sdram_page_reader_pkg::*;

   localparam logic [14:0] BASE   = 15'h7FFE;
   localparam int          FPAGES = 6;
   localparam int          DEPTH  = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_page_reader_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

   sdram_page_reader #(
      .BASE_PAGE   (BASE),
      .FRAME_PAGES (16'(FPAGES)),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .sram_clk (clk),
      .rst_n    (rst_n),
      .bus_if   (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic [15:0] exp_q[$];
   int          page_m;
   bit          discard, done_pend, exp_uf, accepting;
   int          r_st, r_cnt, r_wait;
   logic [14:0] r_addr, exp_addr;
   int          n_accept = 0, n_bursts = 0, fd_count = 0;
   logic [31:0] acc_level;

   // Responder: accepts a read, returns 512 ramp words with random gaps, then goes idle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_if.in_idle  <= 1'b1;
         bus_if.w_fifo   <= 1'b0;
         bus_if.s2f_data <= '0;
         r_st = 0; r_cnt = 0; exp_q.delete(); page_m = 0; discard = 0; done_pend = 0;
      end else begin
         accepting = (r_st == 0) && bus_if.in_idle &&
                     (bus_if.user_interface_command == CMD_READ);
         if (bus_if.w_fifo && !discard && !bus_if.frame_start) exp_q.push_back(bus_if.s2f_data);
         if (done_pend) begin
            done_pend = 0;
            if (discard || bus_if.frame_start) begin
               exp_q.delete(); page_m = 0;
            end else begin
               page_m++;
            end
            discard = 0;
         end else if (bus_if.frame_start) begin
            if (r_st != 0 || accepting) discard = 1;
            else begin
               exp_q.delete(); page_m = 0;
            end
         end
         case (r_st)
            0: if (accepting) begin
               exp_addr = BASE + 15'(page_m);
               check("cmd_f_addr", 32'(bus_if.f_addr), 32'(exp_addr));
               check("cmd_in_frame", 32'(page_m < FPAGES), 32'd1);
               acc_level = 32'(bus_if.fifo_level);
               check("cmd_room", 32'(acc_level <= 32'(DEPTH - BURST_LEN)), 32'd1);
               n_accept++;
               r_addr = bus_if.f_addr;
               bus_if.in_idle <= 1'b0;
               r_cnt = 0; r_wait = $urandom_range(1, 3); r_st = 1;
            end
            1: begin
               r_wait--;
               if (r_wait == 0) r_st = 2;
            end
            2: begin
               check("cmd_low_in_burst", 32'(bus_if.user_interface_command), 32'(CMD_IDLE));
               if ($urandom_range(0, 3) != 0) begin
                  bus_if.w_fifo   <= 1'b1;
                  bus_if.s2f_data <= {r_addr[6:0], 9'd0} + 16'(r_cnt);
                  r_cnt++;
                  if (r_cnt == 512) begin
                     r_st = 3; r_wait = $urandom_range(1, 3);
                  end
               end else begin
                  bus_if.w_fifo <= 1'b0;
               end
            end
            default: begin
               bus_if.w_fifo <= 1'b0;
               check("cmd_low_at_idle", 32'(bus_if.user_interface_command), 32'(CMD_IDLE));
               r_wait--;
               if (r_wait == 0) begin
                  bus_if.in_idle <= 1'b1;
                  r_st = 0; done_pend = 1; n_bursts++;
               end
            end
         endcase
      end
   end

   // Consumer-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_uf = 0;
      end else begin
         check("pix_valid", 32'(bus_if.pix_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("pix_data", 32'(bus_if.pix_data), 32'(exp_q[0]));
         check("underflow", 32'(bus_if.underflow), 32'(exp_uf));
         if (bus_if.frame_done) begin
            fd_count++;
            check("frame_done_page", 32'(page_m), 32'(FPAGES));
         end
         if (bus_if.frame_start) exp_uf = 0;
         else if (bus_if.pix_ready && exp_q.size() == 0 && bus_if.enable) exp_uf = 1;
         if (bus_if.pix_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_accepts(input int target, input string tag);
      int t = 0;
      while (n_accept < target && t < 20000) begin step(1); t++; end
      check(tag, 32'(n_accept), 32'(target));
   endtask

   task automatic wait_bursts(input int target, input string tag);
      int t = 0;
      while (n_bursts < target && t < 20000) begin step(1); t++; end
      check(tag, 32'(n_bursts), 32'(target));
   endtask

   task automatic pulse_frame_start();
      bus_if.frame_start = 1'b1;
      step(1);
      bus_if.frame_start = 1'b0;
   endtask

   initial begin
      int na, t;
      logic [15:0] first_word;
      bus_if.enable = 1'b0; bus_if.frame_start = 1'b0; bus_if.pix_ready = 1'b0;
      step(2);
      check("rst_cmd", 32'(bus_if.user_interface_command), 32'(CMD_IDLE));
      check("rst_f_addr", 32'(bus_if.f_addr), 32'(BASE));
      check("rst_pix_valid", 32'(bus_if.pix_valid), 32'd0);
      check("rst_level", 32'(bus_if.fifo_level), 32'd0);
      check("rst_underflow", 32'(bus_if.underflow), 32'd0);
      check("rst_frame_done", 32'(bus_if.frame_done), 32'd0);
      rst_n = 1'b1;
      step(2);

      // First page lands whole in the FIFO, ramp starts at the page base.
      bus_if.enable = 1'b1;
      wait_accepts(1, "first_cmd");
      wait_bursts(1, "first_burst");
      step(2);
      first_word = {BASE[6:0], 9'd0};
      check("level_one_page", 32'(bus_if.fifo_level), 32'd512);
      check("first_word", 32'(bus_if.pix_data), 32'(first_word));

      // Without a consumer exactly two pages fit.
      wait_bursts(2, "second_burst");
      step(50);
      check("level_full", 32'(bus_if.fifo_level), 32'(DEPTH));
      check("two_cmds", 32'(n_accept), 32'd2);
      step(300);
      check("no_third_cmd", 32'(n_accept), 32'd2);

      // Drain: the rest of the frame is fetched, then fetching stops.
      bus_if.pix_ready = 1'b1;
      t = 0;
      while (fd_count < 1 && t < 20000) begin step(1); t++; end
      check("frame_done_seen", 32'(fd_count), 32'd1);
      t = 0;
      while (bus_if.pix_valid && t < 5000) begin step(1); t++; end
      step(300);
      check("frame_cmds", 32'(n_accept), 32'(FPAGES));
      check("frame_done_once", 32'(fd_count), 32'd1);
      check("level_drained", 32'(bus_if.fifo_level), 32'd0);
      exp_addr = BASE + 15'(FPAGES);
      check("f_addr_end", 32'(bus_if.f_addr), 32'(exp_addr));
      check("underflow_set", 32'(bus_if.underflow), 32'd1);

      // Restart from idle.
      bus_if.pix_ready = 1'b0;
      pulse_frame_start();
      check("uf_cleared_idle", 32'(bus_if.underflow), 32'd0);
      check("f_addr_restart", 32'(bus_if.f_addr), 32'(BASE));

      // Restart in the middle of the last page of the frame.
      bus_if.pix_ready = 1'b1;
      wait_accepts(2 * FPAGES, "reach_page5");
      t = 0;
      while (r_cnt < 200 && t < 5000) begin step(1); t++; end
      bus_if.pix_ready = 1'b0;
      na = n_accept;
      pulse_frame_start();
      wait_accepts(na + 1, "cmd_after_restart");
      check("level_before_cmd", acc_level, 32'd0);
      check("no_frame_done_restart", 32'(fd_count), 32'd1);

      // Reset in the middle of a burst.
      t = 0;
      while (!(r_st == 2 && r_cnt >= 100) && t < 5000) begin step(1); t++; end
      rst_n = 1'b0;
      #1;
      check("mid_rst_cmd", 32'(bus_if.user_interface_command), 32'(CMD_IDLE));
      check("mid_rst_level", 32'(bus_if.fifo_level), 32'd0);
      check("mid_rst_f_addr", 32'(bus_if.f_addr), 32'(BASE));
      check("mid_rst_valid", 32'(bus_if.pix_valid), 32'd0);
      step(2);
      rst_n = 1'b1;
      na = n_accept;
      wait_accepts(na + 1, "cmd_after_reset");
      check("level_after_reset", acc_level, 32'd0);

      // Underflow with an empty FIFO, cleared by frame_start.
      bus_if.enable = 1'b0;
      bus_if.pix_ready = 1'b1;
      t = 0;
      while (!(r_st == 0 && !done_pend) && t < 5000) begin step(1); t++; end
      step(3);
      pulse_frame_start();
      check("uf_clear_disabled", 32'(bus_if.underflow), 32'd0);
      check("level_flushed", 32'(bus_if.fifo_level), 32'd0);
      bus_if.enable = 1'b1;
      step(1);
      check("uf_set", 32'(bus_if.underflow), 32'd1);
      step(20);
      check("uf_sticky", 32'(bus_if.underflow), 32'd1);
      bus_if.pix_ready = 1'b0;
      pulse_frame_start();
      check("uf_cleared", 32'(bus_if.underflow), 32'd0);
      bus_if.enable = 1'b0;
      t = 0;
      while (!(r_st == 0 && !done_pend) && t < 5000) begin step(1); t++; end
      step(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
